cic_decim_comb: RTL



---
 rtl/cic_decim_comb.sv | 77 +++++++
 1 files changed

// File: rtl/cic_decim_comb.sv
// cic_decim_comb: keeps every R-th accepted integrator sample and runs it through
// N pipelined low-rate comb stages (y = x - x[n-M]), with a sticky overflow flag.
module cic_decim_comb #(
    parameter int WIDTH = 16,
    parameter int N     = 3,
    parameter int M     = 1,
    parameter int R     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] x,
    input  logic             x_valid,
    input  logic             x_overflow,
    input  logic             clear,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             ovf_sticky
);
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(R - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [N:0]       v_q, v_d;
    logic [WIDTH-1:0] out_q [N+1];
    logic [WIDTH-1:0] out_d [N+1];
    logic [WIDTH-1:0] dl_q  [N][M];
    logic [WIDTH-1:0] dl_d  [N][M];
    logic             acc, keep;

    always_comb begin
        acc    = x_valid && !clear;
        keep   = acc && (cnt_q == CNT_MAX);
        cnt_d  = acc ? (keep ? '0 : cnt_q + 1'b1) : cnt_q;
        ovf_d  = ovf_q | (acc & x_overflow);
        out_d  = out_q;
        dl_d   = dl_q;
        v_d[0] = keep;
        if (keep) out_d[0] = x;
        // Delay lines only advance on valid samples, so M counts low-rate samples.
        for (int k = 1; k <= N; k++) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
                out_d[k]     = out_q[k-1] - dl_q[k-1][M-1];
                dl_d[k-1][0] = out_q[k-1];
                for (int m = M - 1; m > 0; m--) dl_d[k-1][m] = dl_q[k-1][m-1];
            end
        end
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            v_d   = '0;
            out_d = '{default: '0};
            dl_d  = '{default: '{default: '0}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            v_q   <= '0;
            out_q <= '{default: '0};
            dl_q  <= '{default: '{default: '0}};
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            v_q   <= v_d;
            out_q <= out_d;
            dl_q  <= dl_d;
        end
    end

    assign y          = out_q[N];
    assign y_valid    = v_q[N];
    assign ovf_sticky = ovf_q;
endmodule
